// File: rtl/toy_ldu_pipe.sv
// toy_ldu_pipe: registered load address-generation and request unit.
// Computes the effective address, the byte strobe positioned by the offset
// within the bus word, and splits bus-word-crossing loads into two beats
// presented on a valid/ready request port with full backpressure.
// Optional build macro: TOY_LDU_MISALIGN_TRAP_EN -- misaligned halfword/word
// loads issue a single error beat with an empty strobe instead of splitting.
module toy_ldu_pipe #(
   parameter int REG_WIDTH  = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int BUS_BYTES  = 4,
   parameter int LSID_WIDTH = 6,
   parameter int OFF_W      = $clog2(BUS_BYTES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_load_vld,
   output logic                  s_load_rdy,
   input  logic [REG_WIDTH-1:0]  s_rs1_val,
   input  logic [REG_WIDTH-1:0]  s_imm,
   input  logic [2:0]            s_funct3,
   input  logic [LSID_WIDTH-1:0] s_lsid,
   output logic                  m_req_vld,
   input  logic                  m_req_rdy,
   output logic [ADDR_WIDTH-1:0] m_req_addr,
   output logic [BUS_BYTES-1:0]  m_req_strb,
   output logic [OFF_W-1:0]      m_req_off,
   output logic [2:0]            m_req_funct3,
   output logic [LSID_WIDTH-1:0] m_req_lsid,
   output logic                  m_req_beat,
   output logic                  m_req_last,
   output logic                  m_req_err
);

   // Strobe window spans two bus words so a crossing load lands in the upper half.
   localparam int WS = 2 * BUS_BYTES;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } state_t;

   // Unshifted byte mask for the access size; zero marks an illegal funct3.
   function automatic logic [WS-1:0] size_mask(input logic [2:0] f3);
      case (f3)
         F3_LB, F3_LBU: size_mask = WS'(4'b0001);
         F3_LH, F3_LHU: size_mask = WS'(4'b0011);
         F3_LW:         size_mask = WS'(4'b1111);
         default:       size_mask = WS'(4'b0000);
      endcase
   endfunction

`ifdef TOY_LDU_MISALIGN_TRAP_EN
   // True when a halfword or word access is not naturally aligned.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3)
         F3_LH, F3_LHU: misaligned = lo[0];
         F3_LW:         misaligned = |lo;
         default:       misaligned = 1'b0;
      endcase
   endfunction
`endif

   state_t                  state_r;
   logic [REG_WIDTH-1:0]    sum_s;
   logic [ADDR_WIDTH-1:0]   ea_s;
   logic [ADDR_WIDTH-1:0]   base_s;
   logic [OFF_W-1:0]        off_s;
   logic [WS-1:0]           wide_strb_s;
   logic                    illegal_s;
   logic                    trap_s;
   logic                    err_s;
   logic                    cross_s;
   logic                    accept_s;
   logic                    transfer_s;
`ifndef TOY_LDU_MISALIGN_TRAP_EN
   logic [ADDR_WIDTH-1:0]   save_addr_r;
   logic [BUS_BYTES-1:0]    save_strb_r;
`endif

   // Address generation, strobe placement and crossing detection for the issuing load.
   always_comb begin
      sum_s     = s_rs1_val + s_imm;
      ea_s      = sum_s[ADDR_WIDTH-1:0];
      off_s     = ea_s[OFF_W-1:0];
      base_s    = {ea_s[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      illegal_s = (size_mask(s_funct3) == {WS{1'b0}});
`ifdef TOY_LDU_MISALIGN_TRAP_EN
      trap_s    = misaligned(s_funct3, ea_s[1:0]);
`else
      trap_s    = 1'b0;
`endif
      if (trap_s) begin
         wide_strb_s = {WS{1'b0}};
      end else begin
         wide_strb_s = size_mask(s_funct3) << off_s;
      end
      err_s   = illegal_s | trap_s;
      cross_s = |wide_strb_s[WS-1:BUS_BYTES];
   end

   assign accept_s   = s_load_vld & s_load_rdy;
   assign transfer_s = m_req_vld & m_req_rdy;
   // Reset gating keeps the issue side closed while rst_n is low.
   assign s_load_rdy = rst_n & (state_r == IDLE) & (~m_req_vld | m_req_rdy);

   // Request output register and split sequencing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         m_req_vld    <= 1'b0;
         m_req_addr   <= {ADDR_WIDTH{1'b0}};
         m_req_strb   <= {BUS_BYTES{1'b0}};
         m_req_off    <= {OFF_W{1'b0}};
         m_req_funct3 <= 3'b000;
         m_req_lsid   <= {LSID_WIDTH{1'b0}};
         m_req_beat   <= 1'b0;
         m_req_last   <= 1'b0;
         m_req_err    <= 1'b0;
`ifndef TOY_LDU_MISALIGN_TRAP_EN
         save_addr_r  <= {ADDR_WIDTH{1'b0}};
         save_strb_r  <= {BUS_BYTES{1'b0}};
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  m_req_vld    <= 1'b1;
                  m_req_addr   <= base_s;
                  m_req_strb   <= wide_strb_s[BUS_BYTES-1:0];
                  m_req_off    <= off_s;
                  m_req_funct3 <= s_funct3;
                  m_req_lsid   <= s_lsid;
                  m_req_beat   <= 1'b0;
                  m_req_err    <= err_s;
`ifdef TOY_LDU_MISALIGN_TRAP_EN
                  m_req_last   <= 1'b1;
`else
                  m_req_last   <= ~cross_s;
                  if (cross_s) begin
                     save_addr_r <= base_s + ADDR_WIDTH'(BUS_BYTES);
                     save_strb_r <= wide_strb_s[WS-1:BUS_BYTES];
                     state_r     <= SPLIT;
                  end
`endif
               end else if (transfer_s) begin
                  m_req_vld <= 1'b0;
               end
            end
            SPLIT: begin
`ifdef TOY_LDU_MISALIGN_TRAP_EN
               state_r <= IDLE;
`else
               // Second beat replaces the first once it has been taken.
               if (transfer_s) begin
                  m_req_addr <= save_addr_r;
                  m_req_strb <= save_strb_r;
                  m_req_beat <= 1'b1;
                  m_req_last <= 1'b1;
                  state_r    <= IDLE;
               end
`endif
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_toy_ldu_pipe.sv
// Self-checking bench for toy_ldu_pipe (default parameters, BUS_BYTES=4).
// A queue of expected request beats is built from the load rules and compared
// against the request port every cycle; directed cases plus random traffic.
module tb_toy_ldu_pipe;

   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010;

   logic        clk = 1'b0;
   logic        rst_n, s_load_vld, s_load_rdy;
   logic [31:0] s_rs1_val, s_imm;
   logic [2:0]  s_funct3;
   logic [5:0]  s_lsid;
   logic        m_req_vld, m_req_rdy;
   logic [31:0] m_req_addr;
   logic [3:0]  m_req_strb;
   logic [1:0]  m_req_off;
   logic [2:0]  m_req_funct3;
   logic [5:0]  m_req_lsid;
   logic        m_req_beat, m_req_last, m_req_err;

   always #5 clk = ~clk;

   toy_ldu_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .s_load_vld(s_load_vld), .s_load_rdy(s_load_rdy),
      .s_rs1_val(s_rs1_val), .s_imm(s_imm), .s_funct3(s_funct3), .s_lsid(s_lsid),
      .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy),
      .m_req_addr(m_req_addr), .m_req_strb(m_req_strb), .m_req_off(m_req_off),
      .m_req_funct3(m_req_funct3), .m_req_lsid(m_req_lsid),
      .m_req_beat(m_req_beat), .m_req_last(m_req_last), .m_req_err(m_req_err)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [1:0]  off;
      logic [2:0]  f3;
      logic [5:0]  lsid;
      logic        beat;
      logic        last;
      logic        err;
   } beat_t;

   beat_t q[$];
   int total = 0;
   int bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expand one accepted load into its expected beats from the byte range it touches.
   task automatic push_load(input logic [31:0] rs1, input logic [31:0] imm,
                            input logic [2:0] f3, input logic [5:0] id);
      logic [31:0] ea;
      int size, off, pos;
      logic [3:0] lo, hi;
      logic err;
      beat_t b;
      ea = rs1 + imm;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      err = (size == 0);
`ifdef TOY_LDU_MISALIGN_TRAP_EN
      if ((size == 2 && ea[0]) || (size == 4 && ea[1:0] != 2'd0)) begin
         err = 1'b1;
         size = 0;
      end
`endif
      off = int'(ea % 32'd4);
      lo = 4'd0;
      hi = 4'd0;
      for (int i = 0; i < size; i++) begin
         pos = off + i;
         if (pos < 4) lo[pos] = 1'b1;
         else hi[pos-4] = 1'b1;
      end
      b.addr = ea - 32'(off);
      b.strb = lo;
      b.off  = 2'(off);
      b.f3   = f3;
      b.lsid = id;
      b.beat = 1'b0;
      b.last = (hi == 4'd0);
      b.err  = err;
      q.push_back(b);
      if (hi != 4'd0) begin
         b.addr = b.addr + 32'd4;
         b.strb = hi;
         b.beat = 1'b1;
         b.last = 1'b1;
         q.push_back(b);
      end
   endtask

   // One clock: drive at negedge, compare, then advance the model at posedge.
   task automatic cyc(input logic rst, input logic vld, input logic [31:0] rs1,
                      input logic [31:0] imm, input logic [2:0] f3,
                      input logic [5:0] id, input logic rdy);
      logic exp_rdy;
      beat_t h;
      @(negedge clk);
      rst_n = rst; s_load_vld = vld; s_rs1_val = rs1; s_imm = imm;
      s_funct3 = f3; s_lsid = id; m_req_rdy = rdy;
      #1;
      exp_rdy = rst && (q.size() == 0 || (q.size() == 1 && rdy));
      check_eq("load_rdy", {63'd0, s_load_rdy}, {63'd0, exp_rdy});
      check_eq("req_vld", {63'd0, m_req_vld}, {63'd0, q.size() != 0});
      if (q.size() != 0) begin
         h = q[0];
         check_eq("addr", {32'd0, m_req_addr}, {32'd0, h.addr});
         check_eq("strb", {60'd0, m_req_strb}, {60'd0, h.strb});
         check_eq("off", {62'd0, m_req_off}, {62'd0, h.off});
         check_eq("funct3", {61'd0, m_req_funct3}, {61'd0, h.f3});
         check_eq("lsid", {58'd0, m_req_lsid}, {58'd0, h.lsid});
         check_eq("beat", {63'd0, m_req_beat}, {63'd0, h.beat});
         check_eq("last", {63'd0, m_req_last}, {63'd0, h.last});
         check_eq("err", {63'd0, m_req_err}, {63'd0, h.err});
      end
      @(posedge clk);
      if (!rst) begin
         q.delete();
      end else begin
         if (rdy && q.size() != 0) void'(q.pop_front());
         if (vld && exp_rdy) push_load(rs1, imm, f3, id);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'd0, 32'd0, LB, 6'd0, 1'b1);
   endtask

   initial begin
      logic [31:0] rs1, imm;
      rst_n = 1'b0; s_load_vld = 1'b0; s_rs1_val = 32'd0; s_imm = 32'd0;
      s_funct3 = 3'd0; s_lsid = 6'd0; m_req_rdy = 1'b0;
      repeat (2) @(posedge clk);
      cyc(1'b0, 1'b1, 32'h1000, 32'd4, LW, 6'd1, 1'b1);
      #1;
      check_eq("rst_vld", {63'd0, m_req_vld}, 64'd0);
      check_eq("rst_addr", {32'd0, m_req_addr}, 64'd0);
      check_eq("rst_strb", {60'd0, m_req_strb}, 64'd0);
      check_eq("rst_last", {63'd0, m_req_last}, 64'd0);

      // Aligned word, then back-to-back byte load
      cyc(1'b1, 1'b1, 32'h1000, 32'd4, LW, 6'd1, 1'b1);
      #1;
      check_eq("p1_addr", {32'd0, m_req_addr}, 64'h1004);
      check_eq("p1_strb", {60'd0, m_req_strb}, 64'hF);
      check_eq("p1_last", {63'd0, m_req_last}, 64'd1);
      check_eq("p1_rdy", {63'd0, s_load_rdy}, 64'd1);
      cyc(1'b1, 1'b1, 32'h1000, 32'd5, LB, 6'd2, 1'b1);
      #1;
      check_eq("p1b_strb", {60'd0, m_req_strb}, 64'h2);
      check_eq("p1b_off", {62'd0, m_req_off}, 64'd1);
      idle(1);

      // Halfword crossing the word boundary (or trap)
      cyc(1'b1, 1'b1, 32'h1000, 32'd3, LH, 6'd7, 1'b1);
      #1;
`ifdef TOY_LDU_MISALIGN_TRAP_EN
      check_eq("p6_strb", {60'd0, m_req_strb}, 64'h0);
      check_eq("p6_err", {63'd0, m_req_err}, 64'd1);
      check_eq("p6_last", {63'd0, m_req_last}, 64'd1);
      cyc(1'b1, 1'b1, 32'h1000, 32'd2, LH, 6'd8, 1'b1);
      #1;
      check_eq("p6b_strb", {60'd0, m_req_strb}, 64'hC);
      check_eq("p6b_err", {63'd0, m_req_err}, 64'd0);
`else
      check_eq("p2_addr0", {32'd0, m_req_addr}, 64'h1000);
      check_eq("p2_strb0", {60'd0, m_req_strb}, 64'h8);
      check_eq("p2_last0", {63'd0, m_req_last}, 64'd0);
      check_eq("p2_rdy", {63'd0, s_load_rdy}, 64'd0);
      cyc(1'b1, 1'b1, 32'h5000, 32'd0, LW, 6'd9, 1'b1);
      #1;
      check_eq("p2_addr1", {32'd0, m_req_addr}, 64'h1004);
      check_eq("p2_strb1", {60'd0, m_req_strb}, 64'h1);
      check_eq("p2_beat1", {63'd0, m_req_beat}, 64'd1);
      check_eq("p2_off1", {62'd0, m_req_off}, 64'd3);
      check_eq("p2_lsid1", {58'd0, m_req_lsid}, 64'd7);
`endif
      idle(2);

      // Word split held under backpressure
      cyc(1'b1, 1'b1, 32'h2000, 32'd2, LW, 6'd3, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'h6000, 32'd0, LB, 6'd4, 1'b0);
      #1;
`ifndef TOY_LDU_MISALIGN_TRAP_EN
      check_eq("p3_addr0", {32'd0, m_req_addr}, 64'h2000);
      check_eq("p3_strb0", {60'd0, m_req_strb}, 64'hC);
      cyc(1'b1, 1'b0, 32'd0, 32'd0, LB, 6'd0, 1'b1);
      #1;
      check_eq("p3_addr1", {32'd0, m_req_addr}, 64'h2004);
      check_eq("p3_strb1", {60'd0, m_req_strb}, 64'h3);
`endif
      idle(2);

      // Address wrap and illegal funct3
      cyc(1'b1, 1'b1, 32'hFFFF_FFF0, 32'hE, LW, 6'd5, 1'b1);
      #1;
`ifndef TOY_LDU_MISALIGN_TRAP_EN
      check_eq("p4_addr0", {32'd0, m_req_addr}, 64'hFFFF_FFFC);
      check_eq("p4_strb0", {60'd0, m_req_strb}, 64'hC);
      cyc(1'b1, 1'b0, 32'd0, 32'd0, LB, 6'd0, 1'b1);
      #1;
      check_eq("p4_addr1", {32'd0, m_req_addr}, 64'h0);
      check_eq("p4_strb1", {60'd0, m_req_strb}, 64'h3);
`endif
      cyc(1'b1, 1'b1, 32'h100, 32'd0, 3'b011, 6'd6, 1'b1);
      #1;
      check_eq("p4_ill_strb", {60'd0, m_req_strb}, 64'h0);
      check_eq("p4_ill_err", {63'd0, m_req_err}, 64'd1);
      check_eq("p4_ill_last", {63'd0, m_req_last}, 64'd1);
      idle(2);

      // Reset right after the first beat of a split
      cyc(1'b1, 1'b1, 32'h1000, 32'd3, LH, 6'd10, 1'b0);
      cyc(1'b0, 1'b0, 32'd0, 32'd0, LB, 6'd0, 1'b0);
      #1;
      check_eq("p5_vld", {63'd0, m_req_vld}, 64'd0);
      check_eq("p5_strb", {60'd0, m_req_strb}, 64'd0);
      cyc(1'b1, 1'b1, 32'h3000, 32'd0, LW, 6'd11, 1'b1);
      #1;
      check_eq("p5_addr", {32'd0, m_req_addr}, 64'h3000);
      check_eq("p5_strbw", {60'd0, m_req_strb}, 64'hF);
      idle(2);

      // Random traffic against the beat-queue model
      for (int n = 0; n < 800; n++) begin
         rs1 = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
         imm = 32'($urandom_range(0, 63)) - 32'd32;
         cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), rs1, imm,
             3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)), ($urandom_range(0, 9) < 7));
      end
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
